regfile_multiport: RTL and testbench

- Parametrised successor to the 32x32 two-read/one-write CPU register file.
- Configurable width, depth and read-port count; two write ports with fixed priority; optional write-to-read bypass.
- Per-register busy scoreboard (reserve on issue, clear on writeback).
- Synchronous active-low reset clears all state.
- Sits in the CPU datapath between decode (reads/reserves) and writeback (writes).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_decoder.sv | 19 +
 rtl/regfile_multiport.sv | 91 +++++++++
 tb/tb_regfile_multiport.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Packed port buses use a fixed "slot k at k*W" layout, computed by slice_lo.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // Address width for a given register count (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Low bit of slot idx in a packed bus of w-bit slots.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_decoder.sv
// Address-to-one-hot decoder.
// Used for both write ports and for the reserve port.
module regfile_decoder
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [DEPTH-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NREAD read ports, two prioritised write ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = addr_w(DEPTH),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NREAD*ADDR_W-1:0] ReadRegister,
  output logic [NREAD*WIDTH-1:0]  ReadData,
  output logic [NREAD-1:0]        ReadBusy,
  input  logic [ADDR_W-1:0]       WriteRegister0,
  input  logic [ADDR_W-1:0]       WriteRegister1,
  input  logic [WIDTH-1:0]        WriteData0,
  input  logic [WIDTH-1:0]        WriteData1,
  input  logic                    RegWrite0,
  input  logic                    RegWrite1,
  input  logic                    Reserve,
  input  logic [ADDR_W-1:0]       ReserveRegister,
  output logic                    WriteConflict,
  output logic [DEPTH*WIDTH-1:0]  AllOutputs
);

  // Register 0 is masked out of every decode when hardwired to zero, which
  // also keeps it out of the bypass path and the scoreboard.
  localparam logic [DEPTH-1:0] LIVE_MASK = {{(DEPTH-1){1'b1}}, (ZERO_REG == 0)};

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] dec_w0, dec_w1, dec_res;
  logic [DEPTH-1:0] hit_w0, hit_w1, hit_res;

  regfile_decoder #(.DEPTH(DEPTH)) u_dec_w0 (
    .addr(WriteRegister0), .en(RegWrite0), .onehot(dec_w0)
  );
  regfile_decoder #(.DEPTH(DEPTH)) u_dec_w1 (
    .addr(WriteRegister1), .en(RegWrite1), .onehot(dec_w1)
  );
  regfile_decoder #(.DEPTH(DEPTH)) u_dec_res (
    .addr(ReserveRegister), .en(Reserve), .onehot(dec_res)
  );

  assign hit_w0  = dec_w0  & LIVE_MASK;
  assign hit_w1  = dec_w1  & LIVE_MASK;
  assign hit_res = dec_res & LIVE_MASK;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy          <= '0;
      WriteConflict <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (hit_w1[i])      regs[i] <= WriteData1;
        else if (hit_w0[i]) regs[i] <= WriteData0;
      end
      // Writeback clears, a same-edge reservation then re-sets.
      busy          <= (busy & ~(hit_w0 | hit_w1)) | hit_res;
      WriteConflict <= RegWrite0 && RegWrite1 && (WriteRegister0 == WriteRegister1);
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;

    assign addr = ReadRegister[slice_lo(k, ADDR_W) +: ADDR_W];

    always_comb begin
      data = regs[addr];
      if (BYPASS != 0) begin
        if (hit_w1[addr])      data = WriteData1;
        else if (hit_w0[addr]) data = WriteData0;
      end
    end

    assign ReadData[slice_lo(k, WIDTH) +: WIDTH] = data;
    assign ReadBusy[k] = busy[addr];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_all
    assign AllOutputs[slice_lo(i, WIDTH) +: WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: one instance without and one with
// bypass, driven in lockstep and checked against a behavioural model.
module tb_regfile_multiport;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic Clk = 1'b0;
  always #50 Clk = ~Clk;

  logic            Reset_n;
  logic [NR*AW-1:0] rr;
  logic [AW-1:0]   wa0, wa1, ra;
  logic [W-1:0]    wd0, wd1;
  logic            we0, we1, res;

  logic [NR*W-1:0] rd_n, rd_b;
  logic [NR-1:0]   rb_n, rb_b;
  logic            wc_n, wc_b;
  logic [D*W-1:0]  all_n, all_b;

  regfile_multiport #(
    .WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_REG(1), .BYPASS(0)
  ) dut_n (
    .Clk(Clk), .Reset_n(Reset_n), .ReadRegister(rr), .ReadData(rd_n), .ReadBusy(rb_n),
    .WriteRegister0(wa0), .WriteRegister1(wa1), .WriteData0(wd0), .WriteData1(wd1),
    .RegWrite0(we0), .RegWrite1(we1), .Reserve(res), .ReserveRegister(ra),
    .WriteConflict(wc_n), .AllOutputs(all_n)
  );

  regfile_multiport #(
    .WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .ReadRegister(rr), .ReadData(rd_b), .ReadBusy(rb_b),
    .WriteRegister0(wa0), .WriteRegister1(wa1), .WriteData0(wd0), .WriteData1(wd1),
    .RegWrite0(we0), .RegWrite1(we1), .Reserve(res), .ReserveRegister(ra),
    .WriteConflict(wc_b), .AllOutputs(all_b)
  );

  logic [31:0]  m_regs [D];
  logic [D-1:0] m_busy;
  logic         m_conf;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic compare_next(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check(e.tag, act, e.val);
  endtask

  function automatic logic [31:0] port_of(input logic [NR*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  function automatic logic [31:0] reg_of(input logic [D*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  task automatic set_port(input int k, input int addr);
    rr[k*AW +: AW] = AW'(addr);
  endtask

  // Advance one clock, updating the model from the inputs that were applied.
  task automatic tick();
    logic [31:0]  nregs [D];
    logic [D-1:0] nbusy;
    logic         nconf;
    nregs = m_regs;
    nbusy = m_busy;
    nconf = m_conf;
    if (!Reset_n) begin
      foreach (nregs[i]) nregs[i] = '0;
      nbusy = '0;
      nconf = 1'b0;
    end else begin
      if (we0 && wa0 != 0) nregs[wa0] = wd0;
      if (we1 && wa1 != 0) nregs[wa1] = wd1;
      if (we0) nbusy[wa0] = 1'b0;
      if (we1) nbusy[wa1] = 1'b0;
      if (res) nbusy[ra] = 1'b1;
      nbusy[0] = 1'b0;
      nconf = we0 && we1 && (wa0 == wa1);
    end
    @(posedge Clk);
    #1;
    m_regs  = nregs;
    m_busy  = nbusy;
    m_conf  = nconf;
    we0     = 1'b0;
    we1     = 1'b0;
    res     = 1'b0;
    Reset_n = 1'b1;
    #1;
  endtask

  // Read every register through the four ports of both instances.
  task automatic sweep_ports(input string tag);
    for (int g = 0; g < D/NR; g++) begin
      for (int k = 0; k < NR; k++) begin
        set_port(k, g*NR + k);
        expect_val({tag, "_data"}, m_regs[g*NR + k]);
        expect_val({tag, "_busy"}, 32'(m_busy[g*NR + k]));
        expect_val({tag, "_data_byp"}, m_regs[g*NR + k]);
      end
      #1;
      for (int k = 0; k < NR; k++) begin
        compare_next(port_of(rd_n, k));
        compare_next(32'(rb_n[k]));
        compare_next(port_of(rd_b, k));
      end
    end
  endtask

  task automatic sweep_all(input string tag);
    for (int i = 0; i < D; i++) begin
      expect_val({tag, "_n"}, m_regs[i]);
      expect_val({tag, "_b"}, m_regs[i]);
      compare_next(reg_of(all_n, i));
      compare_next(reg_of(all_b, i));
    end
  endtask

  task automatic check_conflict(input string tag);
    expect_val({tag, "_n"}, 32'(m_conf));
    expect_val({tag, "_b"}, 32'(m_conf));
    compare_next(32'(wc_n));
    compare_next(32'(wc_b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_busy  = '0;
    m_conf  = 1'b0;
    Reset_n = 1'b0;
    rr = '0; wa0 = '0; wa1 = '0; ra = '0; wd0 = '0; wd1 = '0;
    we0 = 1'b0; we1 = 1'b0; res = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b0;
    tick();
    sweep_ports("init");
    check_conflict("init_conf");

    // Fill, reserve some, then reset with a concurrent write and reserve.
    for (int i = 1; i < D; i++) begin
      wa0 = AW'(i); wd0 = 32'hDEADBEEF; we0 = 1'b1;
      res = (i % 3 == 0); ra = AW'(i);
      tick();
    end
    sweep_all("filled");
    Reset_n = 1'b0;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0123;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_0456;
    res = 1'b1; ra = 5'd4;
    tick();
    sweep_all("reset_all");
    sweep_ports("reset_clear");
    check_conflict("reset_conf");

    // Decoder isolation: one register changes per write.
    for (int i = 1; i < D; i++) begin
      wa0 = AW'(i); wd0 = 32'hF000_0000 + 32'(i); we0 = 1'b1;
      tick();
      sweep_ports("dec");
    end
    sweep_all("dec_all");

    // Register 0: writes, reserve and bypass all suppressed; conflict still flagged.
    set_port(0, 0);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    res = 1'b1; ra = 5'd0;
    #1;
    expect_val("zero_bypass", 32'h0);
    compare_next(port_of(rd_b, 0));
    expect_val("zero_data", 32'h0);
    expect_val("zero_busy", 32'h0);
    expect_val("zero_conf", 32'h1);
    tick();
    compare_next(port_of(rd_n, 0));
    compare_next(32'(rb_n[0]));
    compare_next(32'(wc_n));
    check_conflict("zero_conf_model");

    // Dual write to the same register: port 1 wins, conflict pulses once.
    set_port(0, 7);
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222_2222;
    expect_val("dual_reg7", 32'h2222_2222);
    expect_val("dual_conf", 32'h1);
    tick();
    compare_next(port_of(rd_n, 0));
    compare_next(32'(wc_n));
    check_conflict("dual_conf_model");
    expect_val("dual_conf_clear", 32'h0);
    tick();
    compare_next(32'(wc_n));
    check_conflict("dual_conf_clear_model");

    // Bypass vs. stored value, before and after the edge.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_000A;
    tick();
    set_port(0, 5);
    set_port(2, 8);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_000B;
    #1;
    expect_val("byp_on", 32'h0000_000B);
    expect_val("byp_off", 32'h0000_000A);
    expect_val("byp_other_port", m_regs[8]);
    compare_next(port_of(rd_b, 0));
    compare_next(port_of(rd_n, 0));
    compare_next(port_of(rd_b, 2));
    expect_val("byp_after_n", 32'h0000_000B);
    expect_val("byp_after_b", 32'h0000_000B);
    tick();
    compare_next(port_of(rd_n, 0));
    compare_next(port_of(rd_b, 0));
    set_port(1, 6);
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h0000_0001;
    we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h0000_0002;
    #1;
    expect_val("byp_prio", 32'h0000_0002);
    compare_next(port_of(rd_b, 1));
    tick();
    tick();

    // Scoreboard sequences on register 9.
    set_port(0, 9);
    res = 1'b1; ra = 5'd9;
    expect_val("sb_reserve_n", 32'h1);
    expect_val("sb_reserve_b", 32'h1);
    tick();
    compare_next(32'(rb_n[0]));
    compare_next(32'(rb_b[0]));
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0099;
    res = 1'b1; ra = 5'd9;
    expect_val("sb_wr_res_busy", 32'h1);
    expect_val("sb_wr_res_data", 32'h0000_0099);
    tick();
    compare_next(32'(rb_n[0]));
    compare_next(port_of(rd_n, 0));
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0100;
    expect_val("sb_wb_clear", 32'h0);
    tick();
    compare_next(32'(rb_n[0]));
    res = 1'b1; ra = 5'd9;
    tick();
    res = 1'b1; ra = 5'd9;
    expect_val("sb_double_res", 32'h1);
    tick();
    compare_next(32'(rb_n[0]));
    we0 = 1'b0; wa0 = 5'd9;
    expect_val("sb_no_enable", 32'h1);
    tick();
    compare_next(32'(rb_n[0]));
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0777;
    #1;
    expect_val("sb_busy_not_bypassed", 32'h1);
    compare_next(32'(rb_b[0]));
    expect_val("sb_busy_cleared", 32'h0);
    tick();
    compare_next(32'(rb_b[0]));

    // Pending reservation discarded by reset.
    res = 1'b1; ra = 5'd12;
    tick();
    sweep_ports("pending");
    Reset_n = 1'b0;
    tick();
    sweep_ports("reset_pending");

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
